// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - push-side and serial-line signals of the buffered UART transmitter
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          uart_tx;
    logic          busy;
    logic          tx_done;

    modport master (
        output wr_en, wr_data,
        input  full, empty, fifo_count, overflow, uart_tx, busy, tx_done
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, fifo_count, overflow, uart_tx, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter with optional parity and 16x tick generator
module uart_tx_buffered #(
    parameter int CLKS_PER_TICK = 55,
    parameter int FIFO_DEPTH    = 16,
    parameter int PARITY_MODE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_buffered_if.slave bus
);
    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_TICK - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // 16x-baud tick generator
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Byte FIFO; flags are registered from the next occupancy value
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          empty_q;
    logic          overflow_q;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    assign push = bus.wr_en && !full_q;
    assign head = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q    <= count_d;
            full_q     <= (count_d == COUNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= bus.wr_en && full_q;
        end
    end

    // Frame sequencer; the line level is registered so every transition lands on a tick edge
    state_t      state_q;
    state_t      state_d;
    logic [3:0]  sub_q;
    logic [3:0]  sub_d;
    logic [2:0]  bit_q;
    logic [2:0]  bit_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        par_q;
    logic        par_d;
    logic        tx_q;
    logic        tx_d;
    logic        busy_q;
    logic        busy_d;
    logic        done_q;
    logic        done_d;
    logic        bit_end;
    logic        load;

    assign bit_end = tick && (sub_q == 4'd15);

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;

        if (tick && (state_q != S_IDLE)) begin
            sub_d = sub_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tick && !empty_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_MODE != 0) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    if (!empty_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Loading from IDLE or straight out of STOP: the start bit begins on this edge
        if (load) begin
            state_d = S_START;
            shift_d = head;
            par_d   = (PARITY_MODE == 2) ? ~(^head) : (^head);
            sub_d   = 4'd0;
            bit_d   = 3'd0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
        pop = load;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sub_q   <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.uart_tx    = tx_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered against a frame-level line model
module tb_uart_tx_buffered;
    localparam int CPT  = 4;
    localparam int DEP  = 4;
    localparam int BITC = CPT * 16;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   fall_cyc [3];
    logic prev_line [3];

    always #5 clk = ~clk;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEP)) if0 ();
    uart_tx_buffered_if #(.FIFO_DEPTH(DEP)) if1 ();
    uart_tx_buffered_if #(.FIFO_DEPTH(DEP)) if2 ();

    uart_tx_buffered #(.CLKS_PER_TICK(CPT), .FIFO_DEPTH(DEP), .PARITY_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    uart_tx_buffered #(.CLKS_PER_TICK(CPT), .FIFO_DEPTH(DEP), .PARITY_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1));
    uart_tx_buffered #(.CLKS_PER_TICK(CPT), .FIFO_DEPTH(DEP), .PARITY_MODE(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ln(input int d);
        return (d == 0) ? if0.uart_tx : (d == 1) ? if1.uart_tx : if2.uart_tx;
    endfunction

    function automatic logic bz(input int d);
        return (d == 0) ? if0.busy : (d == 1) ? if1.busy : if2.busy;
    endfunction

    function automatic logic dn(input int d);
        return (d == 0) ? if0.tx_done : (d == 1) ? if1.tx_done : if2.tx_done;
    endfunction

    function automatic logic [31:0] cnt(input int d);
        return (d == 0) ? 32'(if0.fifo_count) : (d == 1) ? 32'(if1.fifo_count) : 32'(if2.fifo_count);
    endfunction

    // Expected line level of bit slot i of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int pm, input int i);
        int ones;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (pm != 0 && i == 9) begin
            ones = $countones(b);
            return (pm == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        end
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (prev_line[d] === 1'b1 && ln(d) === 1'b0) fall_cyc[d] = cyc;
            prev_line[d] = ln(d);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        case (d)
            0: begin if0.wr_en = 1'b1; if0.wr_data = b; end
            1: begin if1.wr_en = 1'b1; if1.wr_data = b; end
            default: begin if2.wr_en = 1'b1; if2.wr_data = b; end
        endcase
        step();
        if0.wr_en = 1'b0; if1.wr_en = 1'b0; if2.wr_en = 1'b0;
        if0.wr_data = 8'($urandom); if1.wr_data = 8'($urandom); if2.wr_data = 8'($urandom);
    endtask

    task automatic wait_start(input int d, input int mark, output int c0);
        int n;
        n = 0;
        while (fall_cyc[d] <= mark && n < 3000) begin
            step();
            n++;
        end
        chk($sformatf("start_seen_d%0d", d), 32'(fall_cyc[d] > mark), 32'd1);
        c0 = cyc - fall_cyc[d];
    endtask

    // Follows one frame from cycle c0 after its start edge to its end, sampling bit centres
    task automatic check_frame(input int d, input logic [7:0] b, input int pm, input int c0,
                               input int exp_cnt2, input bit more, input string tag);
        int n;
        int nb;
        int c;
        logic [10:0] seen;
        nb = (pm == 0) ? 10 : 11;
        n = nb * BITC;
        c = c0;
        seen = '1;
        while (c < n) begin
            step();
            c++;
            if ((c % BITC) == BITC / 2) seen[c / BITC] = ln(d);
            if (c == 2 && exp_cnt2 >= 0) chk({tag, "_count"}, cnt(d), 32'(exp_cnt2));
            if (c == n - 1) chk({tag, "_done_early"}, 32'(dn(d)), 32'd0);
        end
        for (int i = 0; i < nb; i++)
            chk($sformatf("%s_bit%0d", tag, i), 32'(seen[i]), 32'(frame_bit(b, pm, i)));
        chk({tag, "_byte"}, 32'(seen[8:1]), 32'(b));
        chk({tag, "_done"}, 32'(dn(d)), 32'd1);
        chk({tag, "_line_after"}, 32'(ln(d)), more ? 32'd0 : 32'd1);
        chk({tag, "_busy_after"}, 32'(bz(d)), more ? 32'd1 : 32'd0);
        if (!more) begin
            step();
            chk({tag, "_done_pulse"}, 32'(dn(d)), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] x0;
        logic [7:0] b;
        logic [7:0] q [$];
        int mark;
        int c0;
        int mcnt;
        bit expov;

        for (int d = 0; d < 3; d++) begin
            fall_cyc[d]  = -1;
            prev_line[d] = 1'b1;
        end
        if0.wr_en = 1'b0; if1.wr_en = 1'b0; if2.wr_en = 1'b0;
        if0.wr_data = 8'd0; if1.wr_data = 8'd0; if2.wr_data = 8'd0;

        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_uart_tx", 32'(if0.uart_tx), 32'd1);
        chk("rst_empty", 32'(if0.empty), 32'd1);
        chk("rst_full", 32'(if0.full), 32'd0);
        chk("rst_count", cnt(0), 32'd0);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        chk("rst_overflow", 32'(if0.overflow), 32'd0);
        chk("rst_tx_done", 32'(if0.tx_done), 32'd0);
        chk("rst_line1", 32'(ln(1)), 32'd1);
        chk("rst_line2", 32'(ln(2)), 32'd1);

        mark = cyc;
        push(0, 8'h55);
        wait_start(0, mark, c0);
        chk("single_latency_max", 32'((fall_cyc[0] - (mark + 1)) <= CPT), 32'd1);
        chk("single_latency_min", 32'((fall_cyc[0] - (mark + 1)) >= 1), 32'd1);
        chk("single_busy", 32'(bz(0)), 32'd1);
        check_frame(0, 8'h55, 0, c0, -1, 1'b0, "single");

        mark = cyc;
        push(0, 8'hA3);
        push(0, 8'h0F);
        push(0, 8'hFF);
        wait_start(0, mark, c0);
        check_frame(0, 8'hA3, 0, c0, 2, 1'b1, "b2b0");
        check_frame(0, 8'h0F, 0, 0, -1, 1'b1, "b2b1");
        check_frame(0, 8'hFF, 0, 0, -1, 1'b0, "b2b2");

        mark = cyc;
        x0 = 8'($urandom);
        push(0, x0);
        wait_start(0, mark, c0);
        mcnt = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            expov = (mcnt == DEP);
            if (!expov) begin
                mcnt++;
                q.push_back(b);
            end
            push(0, b);
            chk($sformatf("ovf_pulse%0d", i), 32'(if0.overflow), 32'(expov));
            chk($sformatf("ovf_full%0d", i), 32'(if0.full), 32'(mcnt == DEP));
            chk($sformatf("ovf_count%0d", i), cnt(0), 32'(mcnt));
        end
        step();
        chk("ovf_not_sticky", 32'(if0.overflow), 32'd0);
        check_frame(0, x0, 0, cyc - fall_cyc[0], -1, 1'b1, "ovf_head");
        while (q.size() != 0) begin
            b = q.pop_front();
            check_frame(0, b, 0, 0, -1, q.size() != 0, "ovf_q");
        end
        chk("ovf_drained_empty", 32'(if0.empty), 32'd1);

        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? 8'h07 : 8'($urandom);
            mark = cyc;
            push(1, b);
            wait_start(1, mark, c0);
            check_frame(1, b, 1, c0, -1, 1'b0, "par_even");
            mark = cyc;
            push(2, b);
            wait_start(2, mark, c0);
            check_frame(2, b, 2, c0, -1, 1'b0, "par_odd");
        end

        mark = cyc;
        push(0, 8'h81);
        push(0, 8'($urandom));
        push(0, 8'($urandom));
        wait_start(0, mark, c0);
        while ((cyc - fall_cyc[0]) < 4 * BITC + BITC / 2) step();
        chk("mid_data_bit3", 32'(ln(0)), 32'(frame_bit(8'h81, 0, 4)));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_line", 32'(if0.uart_tx), 32'd1);
        chk("mid_rst_empty", 32'(if0.empty), 32'd1);
        chk("mid_rst_count", cnt(0), 32'd0);
        chk("mid_rst_busy", 32'(if0.busy), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        mark = cyc;
        while ((cyc - mark) < 2000) step();
        chk("post_rst_quiet", 32'(fall_cyc[0] > mark), 32'd0);
        chk("post_rst_line", 32'(if0.uart_tx), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- UART transmit channel with an on-chip FIFO and its own 16x-baud tick generator; the sending end for the echo/receive path that uses MLUART_RX.
- Upstream logic pushes bytes at clock rate without waiting on the line.
- The block drains the FIFO as 8N1 frames, with optional parity, on a single serial output.
- Lets firmware-side or RX-side producers send bursts without a send_data/complete handshake per byte.

Parameters:
- CLKS_PER_TICK, 55: clk cycles per 16x-baud tick (100 MHz / 55 / 16 ≈ 113.6 kbaud); must be >= 2.
- FIFO_DEPTH, 16: FIFO entries; power of two, 2..256.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- wr_en, input, 1: push request, sampled at the clk edge.
- wr_data, input, 8: byte to push.
- full, output, 1: FIFO holds FIFO_DEPTH entries.
- empty, output, 1: FIFO holds 0 entries.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- overflow, output, 1: one-clk pulse when wr_en is asserted while full.
- uart_tx, output, 1: serial line, idle high.
- busy, output, 1: high from frame start through end of the stop bit.
- tx_done, output, 1: one-clk pulse at the end of each stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: uart_tx=1, busy=0, tx_done=0, overflow=0, full=0, empty=1, fifo_count=0.
  - Internal: FIFO pointers cleared, tick counter cleared, FSM in IDLE.
  - Reset mid-frame aborts the frame, drives uart_tx high immediately and discards FIFO contents.
- Tick generator:
  - Free-running counter 0..CLKS_PER_TICK-1.
  - tick=1 for one clk when the counter equals CLKS_PER_TICK-1; the counter then wraps to 0.
- One bit = 16 ticks, counted by a 4-bit sub-bit counter.
- FIFO:
  - Push when wr_en && !full. full is evaluated on the pre-edge state, so a push while full is rejected even if a pop happens in the same cycle; overflow pulses and stored data is unchanged.
  - Pop is internal only (FSM load).
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full, empty and fifo_count are registered and update on the edge after the push/pop.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: uart_tx=1, busy=0. On a tick with !empty, pop the head into the shift register, clear the sub-bit and bit counters, go to START. busy and uart_tx=0 take effect on that same edge.
  - START: uart_tx=0 for 16 ticks, then DATA.
  - DATA:
    - uart_tx = shift[0], LSB first.
    - Every 16 ticks: shift right; bit counter +1.
    - After bit 7 completes: go to PAR if PARITY_MODE != 0, else STOP.
  - PAR: uart_tx = XOR of the 8 data bits (even), or its inverse (odd), for 16 ticks, then STOP.
  - STOP: uart_tx=1 for 16 ticks. At the tick ending the stop bit: tx_done=1 for one clk, then either back to IDLE or, if !empty, pop and enter START on the same tick (back-to-back frames, no idle gap).
- Timing:
  - Frame length is exactly 160 ticks (no parity) or 176 ticks (parity).
  - Latency from a push into an empty, idle block to the start-bit falling edge is <= CLKS_PER_TICK clks.
- wr_data is captured at push; later changes on wr_data have no effect.
- Pushes during a frame are accepted normally; the frame in flight is never altered.
- overflow and tx_done are single-cycle pulses, not sticky.

Test Plan:
- Reset sequence: reset=0 for 3 clks, then 1 → uart_tx=1, empty=1, fifo_count=0, busy=0 with no wr_en.
- Single byte (CLKS_PER_TICK=4, PARITY_MODE=0, one bit = 64 clk): push 0x55 → within 4 clks uart_tx falls.
  - Line: start 0 for 64 clk, then 1,0,1,0,1,0,1,0 at 64 clk each, stop 1 for 64 clk.
  - tx_done pulses once 640 clks after the start edge; busy then falls.
- Back-to-back: push 0xA3, 0x0F, 0xFF in consecutive clks → fifo_count peaks at 2 after the first pop.
  - Three contiguous frames (1920 clks) with no idle gap between stop and next start.
  - The bench UART model decodes A3, 0F, FF.
- Full/overflow (FIFO_DEPTH=4): while idle-blocked by an in-progress frame, push 5 bytes → after the first pop, 4 are accepted, full=1, overflow pulses on the rejected push.
  - The decoded stream omits only the rejected byte.
- Parity: PARITY_MODE=1 with 0x07 → parity bit 1, frame 704 clks. PARITY_MODE=2 with 0x07 → parity bit 0.
- Reset mid-frame: assert reset during DATA bit 3 of 0x81 with 2 bytes queued → uart_tx=1 immediately, empty=1.
  - After release, no further frames appear.
